// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - generic pipeline stage register with skid buffer, flush and perf counters
module pipe_stage_buf #(
    parameter int DATA_W = 32,
    parameter int NCH    = 5,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NCH*DATA_W-1:0] in_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NCH*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      bubble_cnt
);

    localparam int W = NCH * DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   main_q, main_nxt;
    logic [W-1:0]   skid_q, skid_nxt;
    logic           in_fire, out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign out_data = main_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    // Main is zeroed on every path into EMPTY so a bubble presents a nop word.
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            state_nxt = EMPTY;
            main_nxt  = '0;
            skid_nxt  = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt = ONE;
                        main_nxt  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_nxt = in_data;
                    end else if (in_fire) begin
                        state_nxt = TWO;
                        skid_nxt  = in_data;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                        main_nxt  = '0;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_nxt = ONE;
                        main_nxt  = skid_q;
                        skid_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    main_nxt  = '0;
                    skid_nxt  = '0;
                end
            endcase
        end
    end

    // Handshake outputs decode registered state only, so out_ready never reaches in_ready.
    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        case (state)
            EMPTY: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
            end
            ONE: begin
                out_valid = 1'b1;
                in_ready  = 1'b1;
            end
            TWO: begin
                out_valid = 1'b1;
                in_ready  = 1'b0;
            end
            default: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (!out_valid && bubble_cnt != CNT_MAX) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed scoreboard bench for pipe_stage_buf
module tb_pipe_stage_buf;

    localparam int DATA_W = 32;
    localparam int NCH    = 2;
    localparam int CNT_W  = 4;
    localparam int W      = NCH * DATA_W;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] sb_q[$];

    pipe_stage_buf #(.DATA_W(DATA_W), .NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .stall_cnt(stall_cnt),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pay(input int a);
        return {32'(a + 1000), 32'(a)};
    endfunction

    // Handshakes are sampled mid-cycle; they commit at the following rising edge.
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                assert (sb_q.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_underflow observed=%0h expected=none", out_data);
                end
                if (sb_q.size() != 0) check("sb_data", 64'(out_data), 64'(sb_q.pop_front()));
            end
            if (flush) sb_q.delete();
            else if (in_valid && in_ready) sb_q.push_back(in_data);
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) step();
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_stall", 64'(stall_cnt), 64'(0));
        check("rst_bubble", 64'(bubble_cnt), 64'(0));
        reset = 1'b0;

        // streaming
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = pay(i);
            step();
            check("stream_valid", 64'(out_valid), 64'(1));
            check("stream_data", 64'(out_data), 64'(pay(i)));
            check("stream_in_ready", 64'(in_ready), 64'(1));
        end
        in_valid = 1'b0;
        step();
        check("stream_drain", 64'(out_valid), 64'(0));
        check("stream_stall", 64'(stall_cnt), 64'(0));

        // skid fill and drain
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = pay(10);
        step();
        in_data = pay(11);
        step();
        in_valid = 1'b0;
        check("skid_in_ready", 64'(in_ready), 64'(0));
        check("skid_out_data", 64'(out_data), 64'(pay(10)));
        check("skid_stall1", 64'(stall_cnt), 64'(1));
        repeat (2) step();
        check("skid_stall3", 64'(stall_cnt), 64'(3));
        out_ready = 1'b1;
        step();
        check("skid_second", 64'(out_data), 64'(pay(11)));
        check("skid_in_ready_back", 64'(in_ready), 64'(1));
        step();
        check("skid_empty", 64'(out_valid), 64'(0));
        check("skid_stall_hold", 64'(stall_cnt), 64'(3));

        // flush with both registers full and a payload offered
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = pay(20);
        step();
        in_data = pay(21);
        step();
        flush = 1'b1; in_data = pay(22);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush2_valid", 64'(out_valid), 64'(0));
        check("flush2_data", 64'(out_data), 64'(0));
        check("flush2_in_ready", 64'(in_ready), 64'(1));
        step();
        check("flush2_no_c", 64'(out_valid), 64'(0));

        // flush in ONE with a real in_fire: the new payload is dropped
        in_valid = 1'b1; in_data = pay(30);
        step();
        flush = 1'b1; in_data = pay(31);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush1_valid", 64'(out_valid), 64'(0));
        step();
        check("flush1_no_c", 64'(out_valid), 64'(0));

        // flush coincident with out_fire
        in_valid = 1'b1; in_data = pay(40);
        step();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_fire_valid", 64'(out_valid), 64'(0));

        // async reset between edges while in TWO
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = pay(50);
        step();
        in_data = pay(51);
        step();
        in_valid = 1'b0;
        check("pre_reset_two", 64'(in_ready), 64'(0));
        #2 reset = 1'b1;
        #1;
        check("arst_in_ready", 64'(in_ready), 64'(1));
        check("arst_out_valid", 64'(out_valid), 64'(0));
        check("arst_out_data", 64'(out_data), 64'(0));
        check("arst_stall", 64'(stall_cnt), 64'(0));
        check("arst_bubble", 64'(bubble_cnt), 64'(0));
        step();
        reset = 1'b0;

        // bubble counter saturation
        repeat (5) step();
        check("bubble_5", 64'(bubble_cnt), 64'(5));
        repeat (15) step();
        check("bubble_sat", 64'(bubble_cnt), 64'(15));
        repeat (3) step();
        check("bubble_sat_hold", 64'(bubble_cnt), 64'(15));
        check("sat_stall", 64'(stall_cnt), 64'(0));
        check("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
